bcd_6d_seg_scanner: RTL and testbench



---
 rtl/bcd_6d_seg_scanner_pkg.sv | 23 ++
 rtl/bcd_to_seg7.sv | 32 +++
 rtl/bcd_6d_seg_scanner.sv | 126 ++++++++++++
 tb/tb_bcd_6d_seg_scanner.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_6d_seg_scanner_pkg.sv
// Shared constants for the 6-digit seven-segment scanner.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package bcd_6d_seg_scanner_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_0    = 7'b0111111;
    localparam seg_pattern_t SEG_1    = 7'b0000110;
    localparam seg_pattern_t SEG_2    = 7'b1011011;
    localparam seg_pattern_t SEG_3    = 7'b1001111;
    localparam seg_pattern_t SEG_4    = 7'b1100110;
    localparam seg_pattern_t SEG_5    = 7'b1101101;
    localparam seg_pattern_t SEG_6    = 7'b1111101;
    localparam seg_pattern_t SEG_7    = 7'b0000111;
    localparam seg_pattern_t SEG_8    = 7'b1111111;
    localparam seg_pattern_t SEG_9    = 7'b1101111;
    localparam seg_pattern_t SEG_DASH = 7'b1000000;
    localparam seg_pattern_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder (active-high).
// Non-decimal nibbles show a dash; blank forces every segment off.
module bcd_to_seg7
    import bcd_6d_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        if (blank) begin
            pattern = SEG_OFF;
        end else begin
            case (nibble)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_6d_seg_scanner.sv
// Six-digit multiplexed seven-segment scanner with frame-synchronous
// double buffering, leading-zero blanking, decimal points and anti-ghost blanking.
module bcd_6d_seg_scanner
    import bcd_6d_seg_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [5:0]  dp_mask,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  DIV_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);
    localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [5:0]     AN_INV    = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
    localparam logic [6:0]     SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic           DP_INV    = (SEG_ACTIVE_LOW != 0);

    logic [CW-1:0]           div_cnt;
    logic [2:0]              idx;
    logic [23:0]             shown;
    logic [23:0]             pending;
    logic                    pend_v;
    logic                    div_wrap;
    logic                    boundary;
    logic                    slot_on;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    cur_dp;
    logic [6:0]              cur_pattern;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign boundary = div_wrap && (idx == IDX_LAST);
    assign slot_on  = (div_cnt >= BLANK_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + CW'(1);
            if (div_wrap) begin
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // Loads between boundaries park in pending; the boundary commits the newest value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shown      <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (boundary) begin
                shown  <= load ? bcd_in : (pend_v ? pending : shown);
                pend_v <= 1'b0;
            end else if (load) begin
                pending <= bcd_in;
                pend_v  <= 1'b1;
            end
        end
    end

    always_comb begin
        lz_blank = '0;
        zero_run = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (shown[i*4 +: 4] == 4'd0);
            lz_blank[i] = zero_run;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_nib   = shown[i*4 +: 4];
                cur_blank = lz_blank[i];
                cur_dp    = dp_mask[i];
            end
        end
    end

    bcd_to_seg7 u_decoder (
        .nibble  (cur_nib),
        .blank   (cur_blank),
        .pattern (cur_pattern)
    );

    // Pin polarity is folded in here so nothing combinational reaches the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_INV;
            seg <= SEG_INV;
            dp  <= DP_INV;
        end else if (slot_on) begin
            an  <= (6'd1 << idx) ^ AN_INV;
            seg <= cur_pattern ^ SEG_INV;
            dp  <= (cur_dp && !cur_blank) ^ DP_INV;
        end else begin
            an  <= AN_INV;
            seg <= SEG_INV;
            dp  <= DP_INV;
        end
    end

endmodule

// File: tb/tb_bcd_6d_seg_scanner.sv
// Scoreboard bench for bcd_6d_seg_scanner: a frame-position model pushes expected
// pin values every clock, and each scenario task pops and checks them inline.
module tb_bcd_6d_seg_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME_LEN = 6 * SCAN_DIV;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        int         slot;
        int         div;
        int         frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] bcd_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [5:0]  dp_mask = '0;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];

    int          pos = 0;
    int          frame_m = 0;
    logic [23:0] m_shown = '0;
    logic [23:0] m_pend = '0;
    logic        m_pv = 1'b0;

    // Active-low pin patterns per nibble; 10..15 show a dash.
    logic [6:0]  seg_low [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    bcd_6d_seg_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYC      (BLANK_CYC),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin : model
        exp_t       e;
        int         slot;
        int         sub;
        int         top_nz;
        logic       blanked;
        logic [3:0] nib;
        if (rst) begin
            pos     <= 0;
            frame_m <= 0;
            m_shown <= '0;
            m_pend  <= '0;
            m_pv    <= 1'b0;
            exp_q.delete();
        end else begin
            slot   = pos / SCAN_DIV;
            sub    = pos % SCAN_DIV;
            top_nz = 0;
            for (int d = 0; d < 6; d++) begin
                if (m_shown[d*4 +: 4] != 4'd0) top_nz = d;
            end
            blanked = blank_lz && (slot > top_nz);
            nib     = m_shown[slot*4 +: 4];
            e.slot  = slot;
            e.div   = sub;
            e.frame = frame_m;
            e.fd    = (pos == FRAME_LEN - 1);
            if (sub < BLANK_CYC) begin
                e.an  = 6'h3F;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e.an  = ~(6'b000001 << slot);
                e.seg = blanked ? 7'h7F : seg_low[nib];
                e.dp  = ~(dp_mask[slot] & ~blanked);
            end
            exp_q.push_back(e);
            if (pos == FRAME_LEN - 1) begin
                m_shown <= load ? bcd_in : (m_pv ? m_pend : m_shown);
                m_pv    <= 1'b0;
                frame_m <= frame_m + 1;
            end else if (load) begin
                m_pend <= bcd_in;
                m_pv   <= 1'b1;
            end
            pos <= (pos == FRAME_LEN - 1) ? 0 : pos + 1;
        end
    end

    task automatic test_reset;
        exp_t e;
        int   n;
        bit   seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL reset_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL reset_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (an !== 6'b111111) begin
            n_bad++;
            $display("[TB] FAIL reset_an got %b want 111111", an);
        end
        n_cmp++;
        if (seg !== 7'b1111111) begin
            n_bad++;
            $display("[TB] FAIL reset_seg got %b want 1111111", seg);
        end
        n_cmp++;
        if (dp !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_dp got %b want 1", dp);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_frame_done got %b want 0", frame_done);
        end
        @(negedge clk);
        rst  = 1'b0;
        n    = 0;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL reset_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL reset_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
            end
            if (frame_done === 1'b1) begin
                seen = 1;
                n    = c;
            end
        end
        n_cmp++;
        if (n != FRAME_LEN) begin
            n_bad++;
            $display("[TB] FAIL first_frame_done got cycle %0d want cycle %0d", n, FRAME_LEN);
        end
    endtask

    task automatic test_digits;
        exp_t e;
        int   fs;
        bit   done;
        blank_lz = 1'b0;
        dp_mask  = 6'b000000;
        fs   = frame_m + 1;
        done = 0;
        for (int c = 0; c < 150 && !done; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL digits_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL digits_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
                if (e.frame == fs && e.div >= 1) begin
                    n_cmp++;
                    if (seg !== 7'b1000000) begin
                        n_bad++;
                        $display("[TB] FAIL digits_pre_zero got %b want 1000000", seg);
                    end
                end
                if (e.frame == fs + 1 && e.slot == 0 && e.div >= 1) begin
                    n_cmp++;
                    if ({an, seg} !== {6'b111110, 7'b0000010}) begin
                        n_bad++;
                        $display("[TB] FAIL digits_d0 got %b_%b want 111110_0000010", an, seg);
                    end
                end
                if (e.frame == fs + 1 && e.slot == 5 && e.div >= 1) begin
                    n_cmp++;
                    if ({an, seg} !== {6'b011111, 7'b1111001}) begin
                        n_bad++;
                        $display("[TB] FAIL digits_d5 got %b_%b want 011111_1111001", an, seg);
                    end
                end
                if (e.frame >= fs + 2) done = 1;
            end
            load = 1'b0;
            if (frame_m == fs && pos == 1) begin
                bcd_in = 24'h123456;
                load   = 1'b1;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL digits_timeout got no frame %0d want it", fs + 2);
        end
    endtask

    task automatic test_lz_blank;
        exp_t       e;
        int         fs;
        bit         done;
        logic [6:0] tbl_a [6];
        logic [6:0] tbl_b [6];
        tbl_a = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        tbl_b = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        blank_lz = 1'b1;
        dp_mask  = 6'b000000;
        fs   = frame_m + 1;
        done = 0;
        for (int c = 0; c < 150 && !done; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL lz_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL lz_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
                if (e.frame == fs + 1 && e.div >= 1) begin
                    n_cmp++;
                    if (seg !== tbl_a[e.slot]) begin
                        n_bad++;
                        $display("[TB] FAIL lz_42_d%0d got %b want %b", e.slot, seg, tbl_a[e.slot]);
                    end
                end
                if (e.frame == fs + 2 && e.div >= 1) begin
                    n_cmp++;
                    if (seg !== tbl_b[e.slot]) begin
                        n_bad++;
                        $display("[TB] FAIL lz_00_d%0d got %b want %b", e.slot, seg, tbl_b[e.slot]);
                    end
                end
                if (e.frame == fs + 2 && e.slot == 3 && e.div >= 1) begin
                    n_cmp++;
                    if (an !== 6'b110111) begin
                        n_bad++;
                        $display("[TB] FAIL lz_blank_anode got %b want 110111", an);
                    end
                end
                if (e.frame >= fs + 3) done = 1;
            end
            load = 1'b0;
            if (frame_m == fs && pos == 1) begin
                bcd_in = 24'h000042;
                load   = 1'b1;
            end
            if (frame_m == fs + 1 && pos == 1) begin
                bcd_in = 24'h000000;
                load   = 1'b1;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL lz_timeout got no frame %0d want it", fs + 3);
        end
    endtask

    task automatic test_dash_dp;
        exp_t       e;
        int         fs;
        bit         done;
        logic [6:0] tbl_a [6];
        logic [6:0] tbl_b [6];
        tbl_a = '{7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        tbl_b = '{7'b0111111, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        blank_lz = 1'b0;
        dp_mask  = 6'b000100;
        fs   = frame_m + 1;
        done = 0;
        for (int c = 0; c < 150 && !done; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL dash_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL dash_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
                if (e.frame == fs + 1 && e.div >= 1) begin
                    n_cmp++;
                    if ({seg, dp} !== {tbl_a[e.slot], (e.slot == 2) ? 1'b0 : 1'b1}) begin
                        n_bad++;
                        $display("[TB] FAIL dash_dp_d%0d got %b_%b want %b_%b", e.slot, seg, dp,
                                 tbl_a[e.slot], (e.slot == 2) ? 1'b0 : 1'b1);
                    end
                end
                if (e.frame == fs + 2 && e.div >= 1) begin
                    n_cmp++;
                    if ({seg, dp} !== {tbl_b[e.slot], 1'b1}) begin
                        n_bad++;
                        $display("[TB] FAIL dash_lz_d%0d got %b_%b want %b_1", e.slot, seg, dp,
                                 tbl_b[e.slot]);
                    end
                end
                if (e.frame >= fs + 3) done = 1;
            end
            load = 1'b0;
            if (frame_m == fs && pos == 1) begin
                bcd_in = 24'h00000A;
                load   = 1'b1;
            end
            if (frame_m >= fs + 2) blank_lz = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL dash_timeout got no frame %0d want it", fs + 3);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   fs;
        bit   done;
        blank_lz = 1'b0;
        dp_mask  = 6'b000000;
        fs   = frame_m + 1;
        done = 0;
        for (int c = 0; c < 150 && !done; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL b2b_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
                if (e.frame == fs + 1) begin
                    n_cmp++;
                    if (seg === 7'b1111001) begin
                        n_bad++;
                        $display("[TB] FAIL b2b_no_one got %b want anything but 1111001", seg);
                    end
                end
                if (e.frame == fs + 1 && e.div >= 1) begin
                    n_cmp++;
                    if (seg !== 7'b0100100) begin
                        n_bad++;
                        $display("[TB] FAIL b2b_last_wins_d%0d got %b want 0100100", e.slot, seg);
                    end
                end
                if (e.frame == fs + 2 && e.div >= 1) begin
                    n_cmp++;
                    if (seg !== 7'b0010000) begin
                        n_bad++;
                        $display("[TB] FAIL b2b_boundary_load_d%0d got %b want 0010000", e.slot, seg);
                    end
                end
                if (e.frame >= fs + 3) done = 1;
            end
            load = 1'b0;
            if (frame_m == fs && pos == 2) begin
                bcd_in = 24'h111111;
                load   = 1'b1;
            end
            if (frame_m == fs && pos == 6) begin
                bcd_in = 24'h222222;
                load   = 1'b1;
            end
            if (frame_m == fs + 1 && pos == FRAME_LEN - 1) begin
                bcd_in = 24'h999999;
                load   = 1'b1;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL b2b_timeout got no frame %0d want it", fs + 3);
        end
    endtask

    task automatic test_blank_interval;
        exp_t e;
        blank_lz = 1'b0;
        dp_mask  = 6'b101010;
        for (int c = 0; c < 3 * FRAME_LEN; c++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL blank_sb_empty got empty queue want an entry");
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    n_bad++;
                    $display("[TB] FAIL blank_sb_pins got %b_%b_%b_%b want %b_%b_%b_%b",
                             an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
                if (e.div == 0) begin
                    n_cmp++;
                    if (an !== 6'b111111) begin
                        n_bad++;
                        $display("[TB] FAIL blank_slot_start got %b want 111111", an);
                    end
                end
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("[TB] FAIL blank_one_hot got %b want at most one low anode", an);
            end
        end
    endtask

    initial begin
        $display("[TB] starting bcd_6d_seg_scanner bench");
        test_reset();
        test_digits();
        test_lz_blank();
        test_dash_dp();
        test_back_to_back();
        test_blank_interval();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
